// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dmem_store_buffer
// Description : Data-side memory stage. Posts CPU stores into an in-order
//               FIFO that drains to a valid/ack backing memory in the
//               background. Loads are forwarded from the FIFO or fetched
//               from memory over the same single port.
//               Optional feature macro: SB_FORWARD_EN (store-to-load
//               forwarding with youngest-match priority).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_mem_w,
  input  logic                   cpu_mem_r,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_wdata,
  output logic [DW-1:0]          cpu_rdata,
  output logic                   cpu_stall,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ack,
  input  logic [DW-1:0]          mem_rdata,
  output logic [$clog2(DEPTH):0] sb_count,
  output logic                   sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WA = AW - 2;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t        r_state;
  logic [WA-1:0] r_ent_addr [DEPTH];
  logic [DW-1:0] r_ent_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_req;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_last;

  logic          w_load;
  logic          w_full;
  logic          w_enq;
  logic          w_deq;
  logic          w_rd_done;
  logic          w_hit;
  logic [DW-1:0] w_fwd_data;
  logic          w_rd_go;
  logic          w_unused_addr;

  // Byte offset within the word is irrelevant for word accesses.
  assign w_unused_addr = ^cpu_addr[1:0];

  // A simultaneous store and load is illegal; the store wins.
  assign w_load    = cpu_mem_r && !cpu_mem_w;
  assign w_full    = (r_count == C_FULL);
  assign w_enq     = cpu_mem_w && !w_full;
  assign w_deq     = (r_state == S_WR) && mem_ack;
  assign w_rd_done = (r_state == S_RD) && mem_ack;

`ifdef SB_FORWARD_EN
  logic [DEPTH-1:0] w_match;
  logic [PW-1:0]    w_age [DEPTH];
  logic [PW-1:0]    w_best;

  // Per-entry comparator; age is the distance from head, so larger is younger.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign w_age[gi]   = PW'(gi) - r_head;
    assign w_match[gi] = ({1'b0, w_age[gi]} < r_count) &&
                         (r_ent_addr[gi] == cpu_addr[AW-1:2]);
  end

  // Youngest matching entry supplies the forwarded data.
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    w_best     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_match[i] && (!w_hit || (w_age[i] > w_best))) begin
        w_hit      = 1'b1;
        w_best     = w_age[i];
        w_fwd_data = r_ent_data[i];
      end
    end
  end

  // A miss never overlaps a buffered address, so it may bypass pending drains.
  assign w_rd_go = w_load && !w_hit;
`else
  assign w_hit      = 1'b0;
  assign w_fwd_data = '0;
  // Without forwarding a load may only read once every older store is out.
  assign w_rd_go    = w_load && (r_count == '0);
`endif

  // Stall on a full buffer or on any load that cannot complete this cycle.
  assign cpu_stall = rst && ((cpu_mem_w && w_full) ||
                             (w_load && !w_hit && !w_rd_done));

  // Read data: memory pass-through on ack, else forwarded, else last value.
  assign cpu_rdata = w_rd_done           ? mem_rdata  :
                     (w_load && w_hit)   ? w_fwd_data : r_last;

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign sb_count  = r_count;
  assign sb_empty  = (r_count == '0);

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent_addr[i] <= '0;
        r_ent_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_ent_addr[r_tail] <= cpu_addr[AW-1:2];
        r_ent_data[r_tail] <= cpu_wdata;
        r_tail             <= r_tail + PW'(1);
      end
      if (w_deq) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Memory-port sequencer; request fields stay stable until acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rd_go) begin
            r_state <= S_RD;
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= {cpu_addr[AW-1:2], 2'b00};
          end else if (r_count != '0) begin
            r_state <= S_WR;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= {r_ent_addr[r_head], 2'b00};
            r_wdata <= r_ent_data[r_head];
          end else if (w_enq) begin
            // Empty buffer: the incoming store is the head, issue it directly.
            r_state <= S_WR;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= {cpu_addr[AW-1:2], 2'b00};
            r_wdata <= cpu_wdata;
          end
        end
        S_WR: begin
          if (mem_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        S_RD: begin
          if (mem_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Remember the most recently returned load value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= '0;
    end else if (w_rd_done || (w_load && w_hit)) begin
      r_last <= cpu_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_store_buffer
// Description : Self-checking bench for dmem_store_buffer with a queue-based
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_mem_w = 1'b0;
  logic          cpu_mem_r = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  wire           mem_ack;
  logic [DW-1:0] mem_rdata = '0;
  logic [CW-1:0] sb_count;
  logic          sb_empty;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_w(cpu_mem_w), .cpu_mem_r(cpu_mem_r), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  bit   ack_auto   = 1'b1;
  int   ack_delay  = 0;
  logic ack_manual = 1'b0;
  logic auto_ack   = 1'b0;
  int   wcnt       = 0;

  always @(posedge clk) begin
    #1;
    if (mem_req) wcnt++;
    else wcnt = 0;
    auto_ack = mem_req && (wcnt >= ack_delay + 1);
  end
  assign mem_ack = ack_auto ? auto_ack : ack_manual;

  logic [AW-1:0] wr_log[$];
  always @(negedge clk) begin
    if (rst && mem_req && mem_ack && mem_we) wr_log.push_back(mem_addr);
  end

  always @(negedge clk) begin
    if (rst) assert (!(cpu_mem_w && cpu_mem_r));
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          m_q[$];
  bit            m_busy = 1'b0;
  bit            m_we   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_last  = '0;

  function automatic void m_lookup(input logic [AW-1:0] a, output bit h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    for (int i = 0; i < m_q.size(); i++) begin
      if (FWD && (m_q[i].a[AW-1:2] == a[AW-1:2])) begin
        h = 1'b1;
        d = m_q[i].d;
      end
    end
  endfunction

  always @(posedge clk or negedge rst) begin : m_upd
    bit            ld, h, enq, go_rd;
    logic [DW-1:0] fd;
    int            n;
    ent_t          e;
    if (!rst) begin
      m_q.delete();
      m_busy = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_last = '0;
    end else begin
      n   = m_q.size();
      ld  = cpu_mem_r && !cpu_mem_w;
      m_lookup(cpu_addr, h, fd);
      enq = cpu_mem_w && (n < DEPTH);
      if (ld && h) m_last = fd;
      if (m_busy) begin
        if (mem_ack) begin
          if (m_we) void'(m_q.pop_front());
          else      m_last = mem_rdata;
          m_busy = 1'b0;
        end
      end else begin
        go_rd = ld && !h && (FWD || n == 0);
        if (go_rd) begin
          m_busy = 1'b1; m_we = 1'b0; m_addr = {cpu_addr[AW-1:2], 2'b00};
        end else if (n > 0) begin
          m_busy = 1'b1; m_we = 1'b1; m_addr = m_q[0].a; m_wdata = m_q[0].d;
        end else if (enq) begin
          m_busy = 1'b1; m_we = 1'b1; m_addr = {cpu_addr[AW-1:2], 2'b00}; m_wdata = cpu_wdata;
        end
      end
      if (enq) begin
        e.a = {cpu_addr[AW-1:2], 2'b00};
        e.d = cpu_wdata;
        m_q.push_back(e);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    bit            ld, h, rdd, st;
    logic [DW-1:0] fd, er;
    if (rst && chk_en) begin
      ld  = cpu_mem_r && !cpu_mem_w;
      m_lookup(cpu_addr, h, fd);
      rdd = m_busy && !m_we && mem_ack;
      st  = (cpu_mem_w && (m_q.size() == DEPTH)) || (ld && !h && !rdd);
      er  = rdd ? mem_rdata : ((ld && h) ? fd : m_last);
      chk("m_stall", 32'(cpu_stall), 32'(st));
      chk("m_req", 32'(mem_req), 32'(m_busy));
      chk("m_count", 32'(sb_count), m_q.size());
      chk("m_empty", 32'(sb_empty), 32'(m_q.size() == 0));
      chk("m_rdata", cpu_rdata, er);
      if (m_busy) begin
        chk("m_we", 32'(mem_we), 32'(m_we));
        chk("m_addr", mem_addr, m_addr);
        if (m_we) chk("m_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic          ld_we, ld_ack, ld_empty;
  logic [AW-1:0] ld_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    cpu_mem_w = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    while (cpu_stall && n < 80) begin n++; @(negedge clk); end
    chk("store_accept", 32'(cpu_stall), 0);
    tick();
    cpu_mem_w = 1'b0;
  endtask

  task automatic do_load(input logic [AW-1:0] a, output logic [DW-1:0] d);
    int n = 0;
    cpu_mem_r = 1'b1; cpu_addr = a;
    @(negedge clk);
    while (cpu_stall && n < 80) begin n++; @(negedge clk); end
    chk("load_done", 32'(cpu_stall), 0);
    d = cpu_rdata; ld_we = mem_we; ld_addr = mem_addr; ld_ack = mem_ack; ld_empty = sb_empty;
    tick();
    cpu_mem_r = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    @(negedge clk);
    while (!sb_empty && n < 80) begin n++; @(negedge clk); end
    chk("drain_done", 32'(sb_empty), 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [DW-1:0] d;
    int            n5;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_count", 32'(sb_count), 0);
    chk("rst_empty", 32'(sb_empty), 1);
    chk("rst_stall", 32'(cpu_stall), 0);
    rst = 1'b1;
    chk_en = 1'b1;
    tick();

    // 1: single store drains in the next cycle
    do_store(32'h100, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_req", 32'(mem_req), 1);
    chk("t1_we", 32'(mem_we), 1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_empty", 32'(sb_empty), 1);
    tick();

    // 2: fill to DEPTH, fifth store stalls even with a same-cycle ack
    ack_auto = 1'b0; ack_manual = 1'b0;
    for (int i = 0; i < 4; i++) do_store(32'(i * 4), 32'(16 + i));
    cpu_mem_w = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h99;
    @(negedge clk);
    chk("t2_full_stall", 32'(cpu_stall), 1);
    chk("t2_count4", 32'(sb_count), 4);
    tick(); ack_manual = 1'b1;
    @(negedge clk);
    chk("t2_ack_stall", 32'(cpu_stall), 1);
    tick(); ack_manual = 1'b0;
    @(negedge clk);
    chk("t2_count3", 32'(sb_count), 3);
    chk("t2_accept", 32'(cpu_stall), 0);
    tick(); cpu_mem_w = 1'b0;
    @(negedge clk);
    chk("t2_count4b", 32'(sb_count), 4);
    tick();
    ack_auto = 1'b1;
    wait_empty();

    // 3: two stores to one address then a load of it
    ack_auto = 1'b0; ack_manual = 1'b0; mem_rdata = 32'h33;
    do_store(32'h200, 32'h11);
    do_store(32'h200, 32'h22);
`ifdef SB_FORWARD_EN
    cpu_mem_r = 1'b1; cpu_addr = 32'h200;
    @(negedge clk);
    chk("t3_fwd_stall", 32'(cpu_stall), 0);
    chk("t3_fwd_data", cpu_rdata, 32'h22);
    tick(); cpu_mem_r = 1'b0;
    ack_auto = 1'b1;
    wait_empty();
`else
    cpu_mem_r = 1'b1; cpu_addr = 32'h200;
    @(negedge clk);
    chk("t3_wait_stall", 32'(cpu_stall), 1);
    tick();
    ack_auto = 1'b1;
    do_load(32'h200, d);
    chk("t3_rd_we", 32'(ld_we), 0);
    chk("t3_rd_addr", ld_addr, 32'h200);
    chk("t3_rd_data", d, 32'h33);
    chk("t3_rd_empty", 32'(ld_empty), 1);
`endif

    // 4: load miss waits behind an in-flight drain
    ack_auto = 1'b1; ack_delay = 3; mem_rdata = 32'h0000CAFE;
    wr_log.delete();
    do_store(32'h300, 32'h5A5A);
    do_load(32'h400, d);
    chk("t4_data", d, 32'h0000CAFE);
    chk("t4_we", 32'(ld_we), 0);
    chk("t4_addr", ld_addr, 32'h400);
    chk("t4_ack_cycle", 32'(ld_ack), 1);
    chk("t4_wr_count", wr_log.size(), 1);
    chk("t4_wr_first", (wr_log.size() > 0) ? wr_log[0] : 32'hFFFFFFFF, 32'h300);

    // 5: asynchronous reset in the middle of a read
    ack_delay = 5;
    cpu_mem_r = 1'b1; cpu_addr = 32'h500;
    n5 = 0;
    @(negedge clk);
    while (!(mem_req && !mem_we) && n5 < 20) begin n5++; @(negedge clk); end
    chk("t5_rd_started", 32'(mem_req && !mem_we), 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_req", 32'(mem_req), 0);
    chk("t5_count", 32'(sb_count), 0);
    chk("t5_stall", 32'(cpu_stall), 0);
    chk("t5_rdata", cpu_rdata, 0);
    cpu_mem_r = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 6: ten stores drain in program order through wrapping pointers
    ack_delay = 0;
    wr_log.delete();
    for (int i = 0; i < 10; i++) do_store(32'(i * 4), 32'(32'h1000 + i));
    wait_empty();
    chk("t6_wr_count", wr_log.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("t6_order", (i < wr_log.size()) ? wr_log[i] : 32'hFFFFFFFF, 32'(i * 4));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
